// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int ZERO_ADDR = 0;

    // Bit offset of port `port` inside a flattened bus of `width`-bit fields.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks clr_idx over the array after reset or clr_req
// and raises ready once the last entry has been zeroed.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    output logic              clear_we,
    output logic              wr_allow,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_t         state_r;
    rf_state_t         state_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_s;
    logic              ready_r;

    // State, clear index and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLEAR;
            idx_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            ready_r <= (state_s == READY);
        end
    end

    // Next-state logic; a clear request always wins over clear completion.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            CLEAR: begin
                if (clr_req) begin
                    idx_s = {ADDR_W{1'b0}};
                end else begin
                    idx_s = idx_r + ADDR_W'(1);
                    if (idx_r == LAST_IDX) begin
                        state_s = READY;
                    end else begin
                        state_s = CLEAR;
                    end
                end
            end
            READY: begin
                if (clr_req) begin
                    state_s = CLEAR;
                    idx_s   = {ADDR_W{1'b0}};
                end else begin
                    state_s = READY;
                end
            end
            default: begin
                state_s = CLEAR;
                idx_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Strobes for the array: clear writes in CLEAR, user writes only in a quiet READY cycle.
    always_comb begin
        clear_we = 1'b0;
        wr_allow = 1'b0;
        if (state_r == CLEAR) begin
            clear_we = 1'b1;
        end else begin
            wr_allow = ~clr_req;
        end
    end

    assign ready   = ready_r;
    assign clr_idx = idx_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, two sync writes (port 1 wins), entry 0 hardwired to zero.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clear_we;
    logic              wr_allow;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr0_s;
    logic              wr1_s;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .ready    (ready),
        .clear_we (clear_we),
        .wr_allow (wr_allow),
        .clr_idx  (clr_idx)
    );

    assign wr0_s = wr_allow & we0 & (waddr0 != ADDR_W'(ZERO_ADDR));
    assign wr1_s = wr_allow & we1 & (waddr1 != ADDR_W'(ZERO_ADDR));

    // Array has no reset so it can map to RAM; port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_idx] <= {DATA_W{1'b0}};
        end else begin
            if (wr0_s) mem[waddr0] <= wdata0;
            if (wr1_s) mem[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[port_lsb(k, ADDR_W) +: ADDR_W];

        // Read mux: zero while clearing or for entry 0, otherwise array (or bypassed write data).
        always_comb begin
            rd_s = {DATA_W{1'b0}};
            if (!ready || ra_s == ADDR_W'(ZERO_ADDR)) begin
                rd_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
            end else if (wr1_s && waddr1 == ra_s) begin
                rd_s = wdata1;
            end else if (wr0_s && waddr0 == ra_s) begin
                rd_s = wdata0;
`endif
            end else begin
                rd_s = mem[ra_s];
            end
        end

        assign rdata[port_lsb(k, DATA_W) +: DATA_W] = rd_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     clr_req = 1'b0;
    logic                     ready;
    logic                     we0 = 1'b0;
    logic                     we1 = 1'b0;
    logic [ADDR_W-1:0]        waddr0 = '0;
    logic [ADDR_W-1:0]        waddr1 = '0;
    logic [DATA_W-1:0]        wdata0 = '0;
    logic [DATA_W-1:0]        wdata1 = '0;
    logic [NUM_RD*ADDR_W-1:0] raddr = '0;
    logic [NUM_RD*DATA_W-1:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_ready;
    int                ref_left;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .ready   (ready),
        .we0     (we0),
        .we1     (we1),
        .waddr0  (waddr0),
        .waddr1  (waddr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // What a reader should see on an address right now, from the register-file rules.
    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (!ref_ready || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (!clr_req) begin
            if (we1 && waddr1 == a) return wdata1;
            if (we0 && waddr0 == a) return wdata0;
        end
`endif
        return ref_mem[a];
    endfunction

    task automatic ref_reset();
        ref_ready = 1'b0;
        ref_left  = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    endtask

    // Advance one clock edge and apply its effect to the model.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (ref_ready) begin
                if (clr_req) begin
                    ref_reset();
                end else begin
                    if (we0 && waddr0 != 5'd0) ref_mem[waddr0] = wdata0;
                    if (we1 && waddr1 != 5'd0) ref_mem[waddr1] = wdata1;
                end
            end else if (clr_req) begin
                ref_left = DEPTH;
            end else begin
                ref_left--;
                if (ref_left == 0) ref_ready = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        raddr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rdy"}, {31'd0, ready}, {31'd0, ref_ready});
        for (int k = 0; k < NUM_RD; k++)
            check(tag, rdata[k*DATA_W +: DATA_W], ref_read(raddr[k*ADDR_W +: ADDR_W]));
    endtask

    task automatic count_clear(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            check(tag, {31'd0, ready}, (i == DEPTH) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] exp_same;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        count_clear("boot_ready");

        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, 5'(a));
            set_rd(1, 5'(DEPTH - 1 - a));
            check_reads("boot_zero");
        end

        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        step(); idle(); set_rd(1, 5'd5);
        #1 check("wr5_p1", rdata[63:32], 32'hDEADBEEF);

        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h00001234;
        step(); idle(); set_rd(0, 5'd0);
        #1 check("reg0", rdata[31:0], 32'd0);

        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h00001111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h00002222;
        step(); idle(); set_rd(0, 5'd7);
        #1 check("coll7", rdata[31:0], 32'h00002222);

`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'd0;
`endif
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5; set_rd(0, 5'd3);
        #1 check("same_cycle3", rdata[31:0], exp_same);
        step(); idle();
        #1 check("after_edge3", rdata[31:0], 32'hA5A5A5A5);

        for (int a = 1; a < DEPTH; a++) begin
            idle();
            if (a % 2 == 1) begin we0 = 1'b1; waddr0 = 5'(a); wdata0 = $urandom; end
            else begin we1 = 1'b1; waddr1 = 5'(a); wdata1 = $urandom; end
            step();
        end
        idle();
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(a + 1));
            check_reads("fill");
        end

        clr_req = 1'b1;
        step(); clr_req = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            we0 = 1'b1; waddr0 = 5'($urandom_range(1, 31)); wdata0 = $urandom;
            we1 = 1'b1; waddr1 = 5'($urandom_range(1, 31)); wdata1 = $urandom;
            step();
            check("clr_ready", {31'd0, ready}, (i == DEPTH) ? 32'd1 : 32'd0);
        end
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(a));
            #1 check("post_clr_zero", rdata[31:0], 32'd0);
        end

        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = 5'($urandom_range(0, 7));
            waddr1 = 5'($urandom_range(0, 7));
            wdata0 = $urandom;
            wdata1 = $urandom;
            clr_req = ($urandom_range(0, 59) == 0);
            set_rd(0, ($urandom_range(0, 1) == 1) ? waddr0 : 5'($urandom_range(0, 7)));
            set_rd(1, ($urandom_range(0, 1) == 1) ? waddr1 : 5'($urandom_range(0, 31)));
            check_reads("rand");
            step();
        end
        idle();
        for (int n = 0; n < 2 * DEPTH && !ref_ready; n++) step();
        check_reads("settle");

        rst = 1'b1;
        #1 check("rst_async_ready", {31'd0, ready}, 32'd0);
        ref_reset();
        step(); step();
        rst = 1'b0;
        count_clear("rst_ready_boot");

        clr_req = 1'b1;
        step(); idle();
        repeat (10) step();
        rst = 1'b1;
        #1 check("rst_midclr_ready", {31'd0, ready}, 32'd0);
        ref_reset();
        step();
        rst = 1'b0;
        count_clear("midclr_reboot");
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(DEPTH - 1 - a));
            check_reads("midclr_zero");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
